framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_writer.sv | 102 ++++++++++
 tb/tb_framebuffer_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// Buffers plotted pixels in a small FIFO and writes them to a framebuffer port.
// Ports: clock/reset; plot,x,y,colour,ready (engine); mem_* (framebuffer); idle.
// Optional: FRAMEBUFFER_CLIP_COUNT_EN adds clip_count (discarded pixel count).
module framebuffer_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        ready,
  input  logic        mem_busy,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic        idle
`ifdef FRAMEBUFFER_CLIP_COUNT_EN
  ,
  output logic [15:0] clip_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

  logic [17:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          in_range;
  logic          accept;
  logic          push;
  logic          pop;
  logic [14:0]   pix_addr;
  logic [17:0]   head;

  assign in_range = (x < 8'd160) && (y < 7'd120);
  assign ready    = (count != FULL);
  assign accept   = plot & ready;
  assign push     = accept & in_range;
  assign pop      = (count != '0) & ~mem_busy;

  // y*160 + x as shifts: 128y + 32y + x
  assign pix_addr = {1'b0, y, 7'b0}
                  + {3'b0, y, 5'b0}
                  + {7'b0, x};

  assign head = fifo_q[rd_ptr];
  assign idle = (count == '0) & ~mem_we;

  // Storage needs no reset; only pointers qualify its contents.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr] <= {pix_addr, colour};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      mem_we   <= 1'b1;
      mem_addr <= head[17:3];
      mem_data <= head[2:0];
    end else begin
      mem_we   <= 1'b0;
    end
  end

`ifdef FRAMEBUFFER_CLIP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clip_count <= '0;
    end else if (accept && !in_range &&
                 clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: expected writes are queued at
// acceptance and a negedge monitor checks every mem_we pulse against them.
module tb_framebuffer_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        ready;
  logic        mem_busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        idle;
`ifdef FRAMEBUFFER_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  framebuffer_writer #(.FIFO_DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .plot(plot),
    .x(x),
    .y(y),
    .colour(colour),
    .ready(ready),
    .mem_busy(mem_busy),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .idle(idle)
`ifdef FRAMEBUFFER_CLIP_COUNT_EN
    ,
    .clip_count(clip_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  int cur_run = 0;
  int max_run = 0;
  logic [17:0] expq [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding pixel.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && mem_we) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d expected none",
                   mem_addr);
        end else begin
          logic [17:0] e;
          e = expq.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e[17:3]));
          check("write_data", 32'(mem_data), 32'(e[2:0]));
        end
      end else begin
        cur_run = 0;
      end
    end
  end

  task automatic send(input int px, input int py,
                      input logic [2:0] pc, input bit exp);
    int n;
    n = 0;
    @(negedge clock);
    plot = 1'b1;
    x = 8'(px);
    y = 7'(py);
    colour = pc;
    while (!ready && n < 200) begin
      stalls++;
      n++;
      @(negedge clock);
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end else begin
      @(posedge clock);
      if (exp) expq.push_back({15'(py * 160 + px), pc});
    end
  endtask

  task automatic stop_plot();
    @(negedge clock);
    plot = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    plot = 1'b0;
    x = '0;
    y = '0;
    colour = '0;
    mem_busy = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 1);
    check("rst_idle", 32'(idle), 1);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single pixel and its latency
    send(5, 2, 3'b101, 1'b1);
    #1;
    check("lat_we_n", 32'(mem_we), 0);
    stop_plot();
    check("lat_we_mid", 32'(mem_we), 0);
    @(negedge clock);
    check("lat_we_n1", 32'(mem_we), 1);
    check("lat_addr", 32'(mem_addr), 325);
    check("lat_data", 32'(mem_data), 5);
    @(negedge clock);
    check("single_idle", 32'(idle), 1);
    check("hold_addr", 32'(mem_addr), 325);

    // Corner pixel and clipped pixels
    send(159, 119, 3'b011, 1'b1);
    send(160, 0, 3'b111, 1'b0);
    send(0, 120, 3'b110, 1'b0);
    stop_plot();
    repeat (4) @(negedge clock);
    check("clip_idle", 32'(idle), 1);
`ifdef FRAMEBUFFER_CLIP_COUNT_EN
    check("clip_count2", 32'(clip_count), 2);
`endif

    // Backpressure: busy fills FIFO, then drains in order
    @(negedge clock);
    mem_busy = 1'b1;
    max_run = 0;
    fork
      begin
        send(10, 1, 3'b001, 1'b1);
        send(11, 1, 3'b010, 1'b1);
        send(12, 1, 3'b011, 1'b1);
        send(13, 1, 3'b100, 1'b1);
        send(14, 1, 3'b101, 1'b1);
        send(15, 1, 3'b110, 1'b1);
      end
      begin
        repeat (6) @(negedge clock);
        check("bp_ready_low", 32'(ready), 0);
        check("bp_no_write", 32'(mem_we), 0);
        mem_busy = 1'b0;
      end
    join
    stop_plot();
    repeat (8) @(negedge clock);
    check("bp_run", 32'(max_run), 6);
    check("bp_idle", 32'(idle), 1);

    // Streaming a full row
    stalls = 0;
    max_run = 0;
    for (int i = 0; i < 160; i++) begin
      send(i, 7, 3'(i), 1'b1);
    end
    stop_plot();
    repeat (4) @(negedge clock);
    check("stream_stalls", 32'(stalls), 0);
    check("stream_run", 32'(max_run), 160);
    check("stream_drained", 32'(expq.size()), 0);

    // Reset mid-stream
    mem_busy = 1'b1;
    send(20, 3, 3'b001, 1'b1);
    send(21, 3, 3'b010, 1'b0);
    send(22, 3, 3'b011, 1'b0);
    stop_plot();
    mem_busy = 1'b0;
    @(negedge clock);
    check("mid_we_before", 32'(mem_we), 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_we_rst", 32'(mem_we), 0);
    check("mid_idle_rst", 32'(idle), 1);
    check("mid_ready_rst", 32'(ready), 1);
    check("mid_addr_rst", 32'(mem_addr), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("mid_idle_after", 32'(idle), 1);
    check("mid_queue", 32'(expq.size()), 0);

`ifdef FRAMEBUFFER_CLIP_COUNT_EN
    // Saturation of the clip counter
    @(negedge clock);
    plot = 1'b1;
    x = 8'd200;
    y = 7'd0;
    repeat (65540) @(negedge clock);
    plot = 1'b0;
    @(negedge clock);
    check("clip_sat", 32'(clip_count), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
